// File: rtl/led_pkg.sv
// Shared definitions for the LED blink driver: state encoding, default timing
// constant and field widths.
package led_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_OFF  = 2'd2,
    ST_DONE = 2'd3
  } led_state_e;

  localparam logic [31:0] DEFAULT_TICK_DIV = 32'd50000;
  localparam int          DEFAULT_COUNT_W  = 8;
  localparam int          DEFAULT_TIME_W   = 16;
  localparam int          DEFAULT_PWM_W    = 4;

endpackage

// File: rtl/led_tick_prescaler.sv
// Divides sysclk into a one-cycle tick every TICK_DIV cycles; clear restarts
// the count at 0. Shared with the debounce and other slow timers.
module led_tick_prescaler
  import led_pkg::*;
#(
  parameter logic [31:0] TICK_DIV = DEFAULT_TICK_DIV
) (
  input  logic sysclk,
  input  logic rst_n,
  input  logic clear,
  output logic tick
);

  logic [31:0] cnt_q;

  // The tick is the wrap cycle, so a full period is exactly TICK_DIV cycles.
  assign tick = (cnt_q == TICK_DIV - 32'd1);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clear || tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 32'd1;
    end
  end

endmodule

// File: rtl/led_blink_driver.sv
// Plays a commanded blink pattern (count, on ticks, off ticks) on led_o and
// pulses done_o at the end. Define LED_BLINK_PWM_EN for duty-controlled ON brightness.
module led_blink_driver
  import led_pkg::*;
#(
  parameter logic [31:0] TICK_DIV = DEFAULT_TICK_DIV,
  parameter int          COUNT_W  = DEFAULT_COUNT_W,
  parameter int          TIME_W   = DEFAULT_TIME_W
`ifdef LED_BLINK_PWM_EN
  ,
  parameter int          PWM_W    = DEFAULT_PWM_W
`endif
) (
  input  logic               sysclk,
  input  logic               rst_n,
  input  logic               cmd_valid_i,
  output logic               cmd_ready_o,
  input  logic [COUNT_W-1:0] cmd_count_i,
  input  logic [TIME_W-1:0]  cmd_on_i,
  input  logic [TIME_W-1:0]  cmd_off_i,
`ifdef LED_BLINK_PWM_EN
  input  logic [PWM_W-1:0]   duty_i,
`endif
  input  logic               abort_i,
  output logic               led_o,
  output logic               busy_o,
  output logic               done_o
);

  led_state_e         state_q, state_d;
  logic [COUNT_W-1:0] rem_q, rem_d;
  logic [TIME_W-1:0]  on_q, on_d;
  logic [TIME_W-1:0]  off_q, off_d;
  logic [TIME_W-1:0]  phase_q, phase_d;
  logic               led_q, led_d;
  logic               tick;

`ifdef LED_BLINK_PWM_EN
  logic [PWM_W-1:0]   pwm_q, pwm_d;
  logic [PWM_W-1:0]   duty_q, duty_d;
`endif

  // A zero duration would never expire; it plays as a single tick instead.
  function automatic logic [TIME_W-1:0] at_least_one(input logic [TIME_W-1:0] v);
    return (v == '0) ? TIME_W'(1) : v;
  endfunction

  led_tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .sysclk (sysclk),
    .rst_n  (rst_n),
    .clear  (state_q == ST_IDLE),
    .tick   (tick)
  );

  // NOTE: defaults first so every path assigns every output; no latches.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    on_d    = on_q;
    off_d   = off_q;
    phase_d = phase_q;

    unique case (state_q)
      ST_IDLE: begin
        phase_d = '0;
        if (cmd_valid_i) begin
          rem_d   = cmd_count_i;
          on_d    = at_least_one(cmd_on_i);
          off_d   = at_least_one(cmd_off_i);
          state_d = (cmd_count_i == '0) ? ST_DONE : ST_ON;
        end
      end
      ST_ON: begin
        if (abort_i) begin
          state_d = ST_IDLE;
        end else if (tick) begin
          if (phase_q == on_q - TIME_W'(1)) begin
            phase_d = '0;
            state_d = ST_OFF;
          end else begin
            phase_d = phase_q + TIME_W'(1);
          end
        end
      end
      ST_OFF: begin
        if (abort_i) begin
          state_d = ST_IDLE;
        end else if (tick) begin
          if (phase_q == off_q - TIME_W'(1)) begin
            phase_d = '0;
            rem_d   = rem_q - COUNT_W'(1);
            state_d = (rem_q == COUNT_W'(1)) ? ST_DONE : ST_ON;
          end else begin
            phase_d = phase_q + TIME_W'(1);
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

`ifdef LED_BLINK_PWM_EN
  // led_o is registered, so compare against the values the counter and duty
  // will hold in the cycle the LED is shown.
  always_comb begin
    pwm_d  = pwm_q + PWM_W'(1);
    duty_d = (state_q == ST_IDLE && cmd_valid_i) ? duty_i : duty_q;
    led_d  = (state_d == ST_ON) && (pwm_d < duty_d);
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_q  <= '0;
      duty_q <= '0;
    end else begin
      pwm_q  <= pwm_d;
      duty_q <= duty_d;
    end
  end
`else
  assign led_d = (state_d == ST_ON);
`endif

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      rem_q   <= '0;
      on_q    <= '0;
      off_q   <= '0;
      phase_q <= '0;
      led_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      on_q    <= on_d;
      off_q   <= off_d;
      phase_q <= phase_d;
      led_q   <= led_d;
    end
  end

  assign led_o       = led_q;
  assign cmd_ready_o = (state_q == ST_IDLE);
  assign busy_o      = (state_q != ST_IDLE);
  assign done_o      = (state_q == ST_DONE);

endmodule

// File: tb/tb_led_blink_driver.sv
// Self-checking bench for led_blink_driver: a cycle-count model of the blink
// timeline checked every cycle, plus hand-computed latency/edge expectations.
`timescale 1ns/1ps
module tb_led_blink_driver;

  localparam int TD      = 4;
  localparam int COUNT_W = 8;
  localparam int TIME_W  = 16;
  localparam int PWM_W   = 4;

  logic               sysclk = 1'b0;
  logic               rst_n;
  logic               cmd_valid_i;
  logic               cmd_ready_o;
  logic [COUNT_W-1:0] cmd_count_i;
  logic [TIME_W-1:0]  cmd_on_i;
  logic [TIME_W-1:0]  cmd_off_i;
  logic [PWM_W-1:0]   duty_i;
  logic               abort_i;
  logic               led_o;
  logic               busy_o;
  logic               done_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 sysclk = ~sysclk;

  led_blink_driver #(
    .TICK_DIV (32'd4),
    .COUNT_W  (COUNT_W),
    .TIME_W   (TIME_W)
  ) dut (
    .sysclk      (sysclk),
    .rst_n       (rst_n),
    .cmd_valid_i (cmd_valid_i),
    .cmd_ready_o (cmd_ready_o),
    .cmd_count_i (cmd_count_i),
    .cmd_on_i    (cmd_on_i),
    .cmd_off_i   (cmd_off_i),
`ifdef LED_BLINK_PWM_EN
    .duty_i      (duty_i),
`endif
    .abort_i     (abort_i),
    .led_o       (led_o),
    .busy_o      (busy_o),
    .done_o      (done_o)
  );

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: a pattern is just "cycles since the accepting edge" against the
  // command's arithmetic timeline.
  bit m_act = 1'b0;
  int m_t, m_cnt, m_on, m_off, m_total;

  always @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      m_act = 1'b0;
      m_t   = 0;
    end else if (!m_act) begin
      if (cmd_valid_i) begin
        m_act   = 1'b1;
        m_t     = 1;
        m_cnt   = int'(cmd_count_i);
        m_on    = (cmd_on_i == 0) ? 1 : int'(cmd_on_i);
        m_off   = (cmd_off_i == 0) ? 1 : int'(cmd_off_i);
        m_total = m_cnt * (m_on + m_off) * TD;
      end
    end else begin
      if (abort_i && m_t <= m_total) m_act = 1'b0;
      else if (m_t > m_total)        m_act = 1'b0;
      else                           m_t++;
    end
  end

  function automatic void model_outs(output int led, output int busy,
                                     output int done, output int ready);
    led = 0; busy = 0; done = 0; ready = 1;
    if (m_act) begin
      busy  = 1;
      ready = 0;
      if (m_t <= m_total)
        led = (((m_t - 1) % ((m_on + m_off) * TD)) < m_on * TD) ? 1 : 0;
      else
        done = 1;
    end
  endfunction

  always @(negedge sysclk) begin
    int e_led, e_busy, e_done, e_ready;
    if (rst_n === 1'b1) begin
      model_outs(e_led, e_busy, e_done, e_ready);
      check("cyc_led",   int'(led_o),       e_led);
      check("cyc_busy",  int'(busy_o),      e_busy);
      check("cyc_done",  int'(done_o),      e_done);
      check("cyc_ready", int'(cmd_ready_o), e_ready);
    end
  end

  // Issue one command (optionally with abort_i high in the accept cycle), then
  // measure done latency, LED-high cycles and LED rising edges from the accept.
  task automatic run_cmd(input string tag, input int c, input int on, input int off,
                         input bit with_abort, input int exp_lat,
                         input int exp_high, input int exp_rise);
    int w = 0;
    int lat = -1;
    int high = 0;
    int rise = 0;
    logic prev = 1'b0;
    while (!cmd_ready_o && w < 100) begin
      @(negedge sysclk);
      w++;
    end
    if (!cmd_ready_o) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_ready_timeout: ready never rose", tag);
    end
    cmd_count_i = COUNT_W'(c);
    cmd_on_i    = TIME_W'(on);
    cmd_off_i   = TIME_W'(off);
    cmd_valid_i = 1'b1;
    abort_i     = with_abort;
    @(posedge sysclk);
    #1;
    cmd_valid_i = 1'b0;
    abort_i     = 1'b0;
    for (int k = 1; k <= 400; k++) begin
      @(negedge sysclk);
      if (led_o) high++;
      if (led_o && !prev) rise++;
      prev = led_o;
      if (done_o) begin
        lat = k;
        break;
      end
    end
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_led_high"}, high, exp_high);
    check({tag, "_led_rises"}, rise, exp_rise);
    @(negedge sysclk);
    check({tag, "_ready_after_done"}, int'(cmd_ready_o), 1);
  endtask

  initial begin
    int done1, done2, n_done;
    #600000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int done1, done2, n_done;
    rst_n       = 1'b0;
    cmd_valid_i = 1'b0;
    cmd_count_i = '0;
    cmd_on_i    = '0;
    cmd_off_i   = '0;
    duty_i      = '1;
    abort_i     = 1'b0;

    #2;
    check("rst_ready", int'(cmd_ready_o), 1);
    check("rst_led",   int'(led_o),       0);
    check("rst_busy",  int'(busy_o),      0);
    check("rst_done",  int'(done_o),      0);
    @(negedge sysclk);
    @(negedge sysclk);
    rst_n = 1'b1;
    @(negedge sysclk);

    run_cmd("single",  1, 2, 3, 1'b0, 21,  8, 1);
    run_cmd("multi",   3, 1, 1, 1'b0, 25, 12, 3);
    run_cmd("count0",  0, 5, 5, 1'b0,  1,  0, 0);
    run_cmd("zerodur", 1, 0, 0, 1'b0,  9,  4, 1);
    run_cmd("abort_idle_accept", 1, 1, 1, 1'b1, 9, 4, 1);

    // Backpressure: valid stays high with new fields through the first pattern.
    cmd_count_i = 8'd1;
    cmd_on_i    = 16'd1;
    cmd_off_i   = 16'd1;
    cmd_valid_i = 1'b1;
    @(posedge sysclk);
    #1;
    cmd_count_i = 8'd2;
    cmd_on_i    = 16'd1;
    cmd_off_i   = 16'd2;
    done1 = -1;
    done2 = -1;
    for (int k = 1; k <= 80; k++) begin
      @(negedge sysclk);
      if (done_o) begin
        if (done1 < 0) done1 = k;
        else begin
          done2 = k;
          break;
        end
      end
      if (k == 10) begin
        check("bp_ready_cycle10", int'(cmd_ready_o), 1);
        @(posedge sysclk);
        #1;
        cmd_valid_i = 1'b0;
      end
    end
    check("bp_first_done",  done1, 9);
    check("bp_second_done", done2, 35);
    @(negedge sysclk);

    // Abort in the middle of the first ON phase.
    cmd_count_i = 8'd2;
    cmd_on_i    = 16'd3;
    cmd_off_i   = 16'd2;
    cmd_valid_i = 1'b1;
    @(posedge sysclk);
    #1;
    cmd_valid_i = 1'b0;
    repeat (4) @(negedge sysclk);
    @(posedge sysclk);
    #1;
    abort_i = 1'b1;
    @(negedge sysclk);
    check("abort_led_before", int'(led_o), 1);
    @(posedge sysclk);
    #1;
    abort_i = 1'b0;
    @(negedge sysclk);
    check("abort_led_after",   int'(led_o),       0);
    check("abort_busy_after",  int'(busy_o),      0);
    check("abort_ready_after", int'(cmd_ready_o), 1);
    n_done = 0;
    repeat (30) begin
      @(negedge sysclk);
      if (done_o) n_done++;
    end
    check("abort_no_done", n_done, 0);

    // Asynchronous reset in the middle of an OFF phase.
    cmd_count_i = 8'd1;
    cmd_on_i    = 16'd1;
    cmd_off_i   = 16'd3;
    cmd_valid_i = 1'b1;
    @(posedge sysclk);
    #1;
    cmd_valid_i = 1'b0;
    repeat (8) @(negedge sysclk);
    check("midoff_led",  int'(led_o),  0);
    check("midoff_busy", int'(busy_o), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_led",   int'(led_o),       0);
    check("async_rst_busy",  int'(busy_o),      0);
    check("async_rst_done",  int'(done_o),      0);
    check("async_rst_ready", int'(cmd_ready_o), 1);
    @(negedge sysclk);
    rst_n = 1'b1;
    @(negedge sysclk);

    run_cmd("after_reset", 1, 1, 1, 1'b0, 9, 4, 1);
    repeat (3) @(negedge sysclk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/led_blink_driver.md
Name: led_blink_driver

Overview:
- Output-side companion to the debounced switch input path: turns blink commands into timed LED drive on a board pin.
- Accepts a command over a valid/ready handshake. Each command carries a blink count plus on and off durations in prescaled ticks.
- Plays the pattern on led_o, then signals completion.
- Sits between control logic (e.g. debounced-button handler) and the top-level LED output; runs entirely on sysclk.

Parameters:
- TICK_DIV, 32'd50000, sysclk cycles per timing tick; legal range 1..2^32-1.
- COUNT_W, 8, width of the blink count field.
- TIME_W, 16, width of the on/off duration fields (in ticks).
- PWM_W, 4, width of the brightness duty field (used only with the optional feature).

Ports:
- sysclk  in  1  system clock.
- rst_n  in  1  reset; asynchronous, active-low.
- cmd_valid_i  in  1  command present.
- cmd_ready_o  out  1  block can accept a command.
- cmd_count_i  in  COUNT_W  number of blinks.
- cmd_on_i  in  TIME_W  ON duration in ticks.
- cmd_off_i  in  TIME_W  OFF duration in ticks.
- abort_i  in  1  synchronous abort of the running pattern.
- led_o  out  1  registered LED drive, active-high.
- busy_o  out  1  pattern in progress.
- done_o  out  1  one-cycle completion pulse.
- duty_i  in  PWM_W  ON-phase brightness; port exists only with LED_BLINK_PWM_EN.

Behaviour:
- Reset values (async reset): state=IDLE, led_o=0, busy_o=0, done_o=0, cmd_ready_o=1, all counters 0.
- States and outputs:
  - IDLE: ready=1, busy=0.
  - ON: led=1.
  - OFF: led=0.
  - DONE: done=1 for 1 cycle, ready=0.
- Handshake: a command is accepted on the edge where cmd_valid_i && cmd_ready_o. cmd_ready_o=1 only in IDLE. All fields are latched on accept; later input changes are ignored.
- Accept with count!=0: next state ON. led_o=1 from the cycle after the accepting edge. Tick prescaler and phase counter clear on accept.
- Accept with count==0: IDLE -> DONE directly. led_o stays 0.
- Zero durations: cmd_on_i==0 or cmd_off_i==0 is treated as 1 tick.
- Phase timing: each ON phase lasts exactly on*TICK_DIV cycles; each OFF phase lasts exactly off*TICK_DIV cycles. Prescaler counts 0..TICK_DIV-1; the tick is the wrap cycle. Phase counter resets on each phase entry.
- Transitions:
  - ON -> OFF at ON expiry.
  - OFF expiry: decrement the remaining count; if it reaches 0 -> DONE, else -> ON.
  - The last blink still plays its full OFF phase.
  - DONE -> IDLE after 1 cycle.
- Total latency: accept edge to done_o high = count*(on+off)*TICK_DIV + 1 cycles. cmd_ready_o returns the cycle after done_o.
- busy_o=1 in ON/OFF/DONE.
- Abort: abort_i in ON/OFF gives IDLE next cycle with led_o=0 and no done_o. abort_i in IDLE/DONE is ignored. If abort_i and cmd_valid_i are both high in IDLE, the command is accepted.
- Reset mid-pattern: immediate return to reset values; no done_o.
- Counter widths are sized so that no wrap is possible within a phase; the prescaler is 32 bits.

Optional Feature:
- Macro LED_BLINK_PWM_EN.
- Defined: adds the duty_i port, latched on accept, plus a free-running PWM_W-bit counter.
  - During ON, led_o = (pwm_cnt < duty).
  - duty==0 gives LED dark during ON; duty==2^PWM_W-1 gives high except 1 of 2^PWM_W cycles.
  - OFF, IDLE and DONE behaviour is unchanged; phase timing is unchanged.
- Undefined: no duty_i port and no PWM counter; led_o=1 for the whole ON phase.

Decomposition:
- Shared package led_pkg: state encoding enum (IDLE, ON, OFF, DONE), default TICK_DIV constant, field-width constants.
- One sub-module, led_tick_prescaler (sysclk, rst_n, clear, tick). It is reusable by the debounce and other timers.

Test Plan (TICK_DIV=4 in sim):
- Single blink: count=1, on=2, off=3 -> led_o high for 8 cycles starting 1 after accept, low for 12, done_o pulse at cycle 21, ready at cycle 22.
- Multi blink: count=3, on=1, off=1 -> three 4-high/4-low periods, exactly 3 rising edges, done_o at cycle 25.
- Zero fields: count=0 -> done_o the cycle after accept, led_o never high. count=1, on=0, off=0 -> behaves as on=1, off=1.
- Backpressure: cmd_valid_i held during a pattern with new fields -> ignored until ready. The second command is accepted the cycle ready=1 and plays the new fields.
- Abort/reset: abort_i mid-ON -> led_o=0 and IDLE next cycle, no done_o. rst_n low mid-OFF -> all outputs at reset values asynchronously.
- With LED_BLINK_PWM_EN, duty=4, PWM_W=4: ON phase shows 4 high of every 16 cycles. duty=0 -> led_o stays 0 throughout.
